dma_priority_arbiter: RTL
=========================

Name: dma_priority_arbiter

Overview:
- Request front end of the 8237A-style DMA controller; sits directly upstream of the DMA timing-control FSM.
- Synchronises and qualifies the four DREQ pins plus software requests, applying mask, polarity and controller-disable settings.
- Arbitrates with fixed or rotating priority and presents a held one-hot VALID_DREQ[3:0] to the timing FSM.
- Drives the DACK pins and the status-register request bits.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the DREQ synchroniser (legal values 2..3).
- SW_REQ_IGNORES_MASK, 1, when 1 a software request is honoured even if that channel's mask bit is set.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  4  raw channel request pins, asynchronous to CLK.
- cmd_disable  in  1  commandReg[2]; 1 = controller disabled, no new grants.
- cmd_rotate  in  1  commandReg[4]; 0 = fixed priority, 1 = rotating priority.
- cmd_dreq_low  in  1  commandReg[6]; 1 = DREQ active low.
- cmd_dack_high  in  1  commandReg[7]; 1 = DACK active high.
- mask  in  4  mask register; 1 = channel masked.
- sw_req  in  4  request register (software requests).
- idle_cycle  in  1  IDLE_CYCLE from the timing FSM; arbitration is allowed only while this is 1.
- dack_en  in  1  validDACK from the timing FSM.
- service_end  in  1  one-cycle pulse at end of service (EOP or terminal count).
- VALID_DREQ  out  4  registered one-hot grant to the timing FSM.
- DACK  out  4  acknowledge pins.
- active_ch  out  2  encoded index of the granted channel.
- req_status  out  4  registered effective requests, feeding statusReg[7:4].

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - Synchroniser flops, grant, VALID_DREQ, active_ch, req_status and dack_seen all clear to 0.
  - Rotation pointer resets to 0, so channel 0 is highest priority.
- Synchroniser: each DREQ bit passes through SYNC_STAGES flops, then is XORed with cmd_dreq_low to give sreq[3:0].
- Effective request:
  - eff[i] = (sreq[i] & ~mask[i]) | (sw_req[i] & (~mask[i] | SW_REQ_IGNORES_MASK)).
  - req_status is eff registered every cycle.
- Priority, fixed mode: channel 0 highest, channel 3 lowest.
- Priority, rotating mode:
  - ptr (2 bits) names the highest-priority channel; order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The pointer persists while cmd_rotate toggles.
  - It is ignored in fixed mode and not updated there.
- States:
  - IDLE: no grant held.
  - GRANT: grant held, dack_seen=0.
  - SERVICE: grant held, dack_seen=1.
- IDLE -> GRANT: when idle_cycle=1, cmd_disable=0 and eff is nonzero, register the winner into VALID_DREQ and active_ch on the same edge.
  - Latency: a DREQ pin edge to VALID_DREQ asserted takes SYNC_STAGES+1 rising edges (3 by default).
- GRANT:
  - dack_en=1 -> SERVICE.
  - eff[active_ch] deasserts before dack_en -> IDLE next edge: VALID_DREQ clears, no pointer update.
- SERVICE:
  - Grant is held regardless of DREQ (demand or block transfer), until service_end.
  - On service_end: -> IDLE, VALID_DREQ cleared; if cmd_rotate=1, ptr <= active_ch+1 mod 4, making the serviced channel lowest priority.
- Simultaneous events:
  - service_end together with a new request in the same cycle: release only. Re-arbitration happens no earlier than the next cycle and still requires idle_cycle=1.
  - service_end while in GRANT is treated like SERVICE (release plus rotate).
- cmd_disable asserted mid-grant does not abort the grant; it only blocks new grants.
- Mask set on the granted channel during SERVICE has no effect until release.
- Mask set on the granted channel in GRANT: the grant withdraws, because eff drops.
- DACK (combinational from registers and dack_en):
  - DACK[i] = (VALID_DREQ[i] & dack_en) XNOR cmd_dack_high, i.e. active level only on the granted channel while dack_en=1.
  - During reset DACK = 4'b1111 when cmd_dack_high=0, and 4'b0000 when cmd_dack_high=1.
- VALID_DREQ is always zero or one-hot; active_ch holds its last value when no grant is held.

Test Plan:
- Reset release with DREQ=4'b0000, cmd_dack_high=0 -> VALID_DREQ=0, DACK=4'b1111, req_status=0; then DREQ=4'b0100 with idle_cycle=1 -> VALID_DREQ=4'b0100 on the 3rd rising edge, active_ch=2.
- Fixed priority, DREQ=4'b1010 -> grant 4'b0010. After dack_en then service_end with DREQ still 4'b1010 -> next grant again 4'b0010.
- Rotating priority, DREQ=4'b1111 held, four complete services -> grant order ch0, ch1, ch2, ch3, and ptr ends at 0.
- mask=4'b0001 with DREQ=4'b0001 -> no grant, req_status=0. Then sw_req=4'b0001 with SW_REQ_IGNORES_MASK=1 -> VALID_DREQ=4'b0001.
- cmd_dreq_low=1, DREQ=4'b1110 -> grant ch0. Drop the request before dack_en -> VALID_DREQ=0 next edge, ptr unchanged.
- Grant held in SERVICE, assert RESET_N=0 mid-cycle -> VALID_DREQ=0 and DACK inactive immediately, without waiting for a clock edge; ptr=0.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA request front end: synchronises DREQ pins, qualifies them with mask and
// software requests, and arbitrates (fixed or rotating) into a held one-hot grant.
module dma_priority_arbiter #(
    parameter int SYNC_STAGES         = 2,
    parameter int SW_REQ_IGNORES_MASK = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic       cmd_disable,
    input  logic       cmd_rotate,
    input  logic       cmd_dreq_low,
    input  logic       cmd_dack_high,
    input  logic [3:0] mask,
    input  logic [3:0] sw_req,
    input  logic       idle_cycle,
    input  logic       dack_en,
    input  logic       service_end,
    output logic [3:0] VALID_DREQ,
    output logic [3:0] DACK,
    output logic [1:0] active_ch,
    output logic [3:0] req_status
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic L_SW_IGNORES_MASK = (SW_REQ_IGNORES_MASK != 0);

    logic [3:0] r_sync [SYNC_STAGES];
    logic [1:0] r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_valid;
    logic [1:0] r_active;
    logic [3:0] r_req_status;

    logic [3:0] w_sreq;
    logic [3:0] w_eff;
    logic [1:0] w_base;
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic [3:0] w_win_onehot;
    logic       w_new_grant;
    logic       w_release;
    logic [3:0] w_dack_act;

    // DREQ is asynchronous to CLK; the first stage may go metastable.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= 4'b0000;
            end
        end else begin
            r_sync[0] <= DREQ;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sreq = r_sync[SYNC_STAGES-1] ^ {4{cmd_dreq_low}};
    assign w_eff  = (w_sreq & ~mask) | (sw_req & (~mask | {4{L_SW_IGNORES_MASK}}));

    // Rotate requests so the highest-priority channel sits at bit 0, pick the
    // lowest set bit, then rotate the index back.
    assign w_base = cmd_rotate ? r_ptr : 2'd0;
    assign w_dbl  = {w_eff, w_eff} >> w_base;
    assign w_rot  = w_dbl[3:0];

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign w_win        = w_base + w_off;
    assign w_win_onehot = 4'b0001 << w_win;
    assign w_new_grant  = idle_cycle && !cmd_disable && (w_eff != 4'b0000);
    assign w_release    = (r_state != ST_IDLE) && service_end;

    // Grant FSM; service_end takes precedence in both held states.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_valid  <= 4'b0000;
            r_active <= 2'd0;
            r_ptr    <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_new_grant) begin
                        r_state  <= ST_GRANT;
                        r_valid  <= w_win_onehot;
                        r_active <= w_win;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_valid <= 4'b0000;
                        if (cmd_rotate) begin
                            r_ptr <= r_active + 2'd1;
                        end
                    end else if (dack_en) begin
                        r_state <= ST_SERVICE;
                    end else if (!w_eff[r_active]) begin
                        r_state <= ST_IDLE;
                        r_valid <= 4'b0000;
                    end
                end
                ST_SERVICE: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_valid <= 4'b0000;
                        if (cmd_rotate) begin
                            r_ptr <= r_active + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_req_status <= 4'b0000;
        end else begin
            r_req_status <= w_eff;
        end
    end

    assign w_dack_act = r_valid & {4{dack_en}};
    assign DACK       = ~(w_dack_act ^ {4{cmd_dack_high}});
    assign VALID_DREQ = r_valid;
    assign active_ch  = r_active;
    assign req_status = r_req_status;

`ifndef SYNTHESIS
    a_valid_onehot0 : assert property (@(posedge CLK) disable iff (!RESET_N)
        $onehot0(r_valid));
`endif

endmodule
